// File: rtl/lt24_write_engine.sv
// rtl/lt24_write_engine.sv - LT24 (ILI9341) 8080 16-bit write bus engine with power-up reset sequencer
//
// Runs the panel reset sequence (lcd_reset_n low, then a settle wait).
// After that it turns each accepted {dc, data} word into one timed wrx strobe.
// csx stays low across a burst until a word flagged in_last has completed.
//
// Ports:
//   clk_clk, reset_reset_n    clock, async active-low reset
//   sw_reset                  1-cycle pulse, re-runs the power-up sequence
//   in_valid/in_ready         word handshake; in_dc, in_last, in_data are the payload
//   init_done, busy           sequence complete / FSM not in IDLE
//   lcd_reset_n, lcd_on       panel reset and power enable
//   csx, dcx, wrx, rdx        8080 bus controls (rdx tied high, write-only)
//   data_out                  8080 data bus
module lt24_write_engine #(
  parameter int RST_LOW_CYC  = 500000,
  parameter int RST_WAIT_CYC = 6000000,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int CNT_W        = 24
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        sw_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_dc,
  input  logic        in_last,
  input  logic [15:0] in_data,
  output logic        init_done,
  output logic        busy,
  output logic        lcd_reset_n,
  output logic        lcd_on,
  output logic        csx,
  output logic        dcx,
  output logic        wrx,
  output logic        rdx,
  output logic [15:0] data_out
);

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_IDLE,
    S_SETUP,
    S_WR_LOW,
    S_WR_HIGH
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOW_END  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_END = CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LOW_END   = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WR_HIGH_END  = CNT_W'(WR_HIGH_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             cnt_en;
  logic             rst_pend;
  logic             last_q;
  logic             accept;
  logic             in_write;

  assign rdx      = 1'b1;
  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_IDLE) & init_done & ~sw_reset & ~rst_pend;
  assign accept   = in_valid & in_ready;
  assign in_write = (state == S_SETUP) | (state == S_WR_LOW) | (state == S_WR_HIGH);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= S_RST_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST_LOW: begin
        if (!sw_reset && cnt == RST_LOW_END) state_nxt = S_RST_WAIT;
      end
      S_RST_WAIT: begin
        if (sw_reset)                     state_nxt = S_RST_LOW;
        else if (cnt == RST_WAIT_END)     state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (sw_reset)                     state_nxt = S_RST_LOW;
        else if (accept)                  state_nxt = S_SETUP;
      end
      S_SETUP:                            state_nxt = S_WR_LOW;
      S_WR_LOW: begin
        if (cnt == WR_LOW_END)            state_nxt = S_WR_HIGH;
      end
      S_WR_HIGH: begin
        // A reset requested mid-word is honoured only once the hold phase ends.
        if (cnt == WR_HIGH_END)           state_nxt = (rst_pend | sw_reset) ? S_RST_LOW : S_IDLE;
      end
      default:                            state_nxt = S_RST_LOW;
    endcase
  end

  // Counter restarts on every state entry, and on sw_reset while already in RST_LOW.
  assign cnt_clr = (state_nxt != state) | (sw_reset & (state == S_RST_LOW));
  assign cnt_en  = (state == S_RST_LOW) | (state == S_RST_WAIT) |
                   (state == S_WR_LOW)  | (state == S_WR_HIGH);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Bus outputs are registered from the transition being taken, so each
  // pin changes on the same edge that enters the state it belongs to.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lcd_reset_n <= 1'b0;
      lcd_on      <= 1'b0;
      csx         <= 1'b1;
      dcx         <= 1'b1;
      wrx         <= 1'b1;
      data_out    <= 16'h0000;
      init_done   <= 1'b0;
      rst_pend    <= 1'b0;
      last_q      <= 1'b0;
    end else if (state_nxt == S_RST_LOW) begin
      lcd_reset_n <= 1'b0;
      csx         <= 1'b1;
      wrx         <= 1'b1;
      init_done   <= 1'b0;
      rst_pend    <= 1'b0;
    end else begin
      if (sw_reset && in_write) rst_pend <= 1'b1;
      case (state)
        S_RST_LOW: begin
          if (state_nxt == S_RST_WAIT) begin
            lcd_reset_n <= 1'b1;
            lcd_on      <= 1'b1;
          end
        end
        S_RST_WAIT: begin
          if (state_nxt == S_IDLE) init_done <= 1'b1;
        end
        S_IDLE: begin
          if (accept) begin
            csx      <= 1'b0;
            dcx      <= in_dc;
            data_out <= in_data;
            last_q   <= in_last;
            wrx      <= 1'b1;
          end
        end
        S_SETUP:   wrx <= 1'b0;
        S_WR_LOW: begin
          if (state_nxt == S_WR_HIGH) wrx <= 1'b1;
        end
        S_WR_HIGH: begin
          if (state_nxt == S_IDLE && last_q) csx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lt24_write_engine.sv
// tb/tb_lt24_write_engine.sv - self-checking bench for lt24_write_engine (params 4/6/2/2)
module tb_lt24_write_engine;

  logic        clk;
  logic        rst_n;
  logic        sw_reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_dc;
  logic        in_last;
  logic [15:0] in_data;
  logic        init_done;
  logic        busy;
  logic        lcd_reset_n;
  logic        lcd_on;
  logic        csx;
  logic        dcx;
  logic        wrx;
  logic        rdx;
  logic [15:0] data_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  lt24_write_engine #(
    .RST_LOW_CYC(4), .RST_WAIT_CYC(6), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .CNT_W(24)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_reset(sw_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dc(in_dc), .in_last(in_last),
    .in_data(in_data), .init_done(init_done), .busy(busy), .lcd_reset_n(lcd_reset_n),
    .lcd_on(lcd_on), .csx(csx), .dcx(dcx), .wrx(wrx), .rdx(rdx), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: one record per observed wrx pulse.
  typedef struct {
    logic        dc;
    logic [15:0] data;
    logic        csx_fall;
    logic        setup_ok;
    int          low;
  } wr_t;

  wr_t         wr_q[$];
  wr_t         cur;
  logic        p_wrx  = 1'b1;
  logic        p_csx  = 1'b1;
  logic        p_dcx  = 1'b1;
  logic [15:0] p_data = 16'h0;
  int          unstable = 0;
  int          rise_cyc = 0;

  always @(negedge clk) begin
    if (wrx === 1'b0) begin
      if (p_wrx === 1'b1) begin
        cur.dc       = dcx;
        cur.data     = data_out;
        cur.csx_fall = csx;
        cur.setup_ok = (p_csx === 1'b0) && (p_dcx === dcx) && (p_data === data_out);
        cur.low      = 1;
      end else begin
        cur.low = cur.low + 1;
        if (dcx !== p_dcx || data_out !== p_data) unstable = unstable + 1;
      end
    end else if (p_wrx === 1'b0) begin
      wr_q.push_back(cur);
      rise_cyc = cyc;
    end
    p_wrx  = wrx;
    p_csx  = csx;
    p_dcx  = dcx;
    p_data = data_out;
  end

  // Present one word and hold it until accepted; returns the accept cycle and csx seen in IDLE.
  task automatic send_word(input logic dc, input logic [15:0] d, input logic last,
                           output int acc, output logic csx_idle);
    int budget = 100;
    in_valid = 1'b1; in_dc = dc; in_data = d; in_last = last;
    #1;
    while (in_ready !== 1'b1 && budget > 0) begin
      @(negedge clk); #1; budget--;
    end
    if (budget == 0) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    acc = cyc;
    csx_idle = csx;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 50;
    while (busy !== 1'b0 && budget > 0) begin
      @(negedge clk); budget--;
    end
    if (budget == 0) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  // Starting at the sample where RST_LOW has just been entered, find where
  // lcd_reset_n rises and where init_done appears.
  task automatic run_init_seq(output int rel_k, output int done_k);
    rel_k = -1; done_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (lcd_reset_n === 1'b1 && rel_k < 0) rel_k = k;
      if (init_done === 1'b1) begin done_k = k; break; end
    end
  endtask

  task automatic test_reset();
    int rel_k, done_k;
    #12;
    n_cmp++; if ({lcd_reset_n, lcd_on, csx, dcx, wrx, rdx} !== 6'b001111) begin n_err++;
      $display("FAIL reset_ctrl: got %b required 001111", {lcd_reset_n, lcd_on, csx, dcx, wrx, rdx}); end
    n_cmp++; if (data_out !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h required 0000", data_out); end
    n_cmp++; if ({in_ready, init_done, busy} !== 3'b001) begin n_err++;
      $display("FAIL reset_status: got %b required 001", {in_ready, init_done, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    run_init_seq(rel_k, done_k);
    n_cmp++; if (rel_k !== 4) begin n_err++; $display("FAIL init_rst_low_len: got %0d required 4", rel_k); end
    n_cmp++; if (done_k !== 10) begin n_err++; $display("FAIL init_done_time: got %0d required 10", done_k); end
    n_cmp++; if ({in_ready, lcd_on, busy} !== 3'b110) begin n_err++;
      $display("FAIL init_ready: got %b required 110", {in_ready, lcd_on, busy}); end
  endtask

  task automatic test_single();
    int a; logic c;
    wr_q.delete();
    send_word(1'b0, 16'h002C, 1'b1, a, c);
    n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL single_csx_before: got %b required 1", c); end
    wait_idle();
    n_cmp++; if (csx !== 1'b1) begin n_err++; $display("FAIL single_csx_after: got %b required 1", csx); end
    n_cmp++; if (wr_q.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d required 1", wr_q.size()); end
    if (wr_q.size() == 1) begin
      n_cmp++; if ({wr_q[0].dc, wr_q[0].data} !== 17'h0002C) begin n_err++;
        $display("FAIL single_word: got dc=%b data=%h required dc=0 data=002c", wr_q[0].dc, wr_q[0].data); end
      n_cmp++; if ({wr_q[0].setup_ok, wr_q[0].csx_fall} !== 2'b10) begin n_err++;
        $display("FAIL single_setup: got ok=%b csx=%b required ok=1 csx=0", wr_q[0].setup_ok, wr_q[0].csx_fall); end
      n_cmp++; if (wr_q[0].low !== 2) begin n_err++; $display("FAIL single_low_len: got %0d required 2", wr_q[0].low); end
    end
  endtask

  task automatic test_burst();
    logic [15:0] words[4];
    int acc[4]; logic c[4];
    words[0] = 16'h002C; words[1] = 16'hF800; words[2] = 16'h07E0; words[3] = 16'h001F;
    wr_q.delete();
    for (int i = 0; i < 4; i++) send_word(i != 0, words[i], i == 3, acc[i], c[i]);
    wait_idle();
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (acc[i] - acc[i-1] !== 6) begin n_err++;
        $display("FAIL burst_gap[%0d]: got %0d required 6", i, acc[i] - acc[i-1]); end
      n_cmp++; if (c[i] !== 1'b0) begin n_err++; $display("FAIL burst_csx_open[%0d]: got %b required 0", i, c[i]); end
    end
    n_cmp++; if (wr_q.size() !== 4) begin n_err++; $display("FAIL burst_count: got %0d required 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      n_cmp++; if ({wr_q[i].dc, wr_q[i].data, wr_q[i].csx_fall} !== {i != 0, words[i], 1'b0}) begin n_err++;
        $display("FAIL burst_word[%0d]: got dc=%b data=%h csx=%b required dc=%b data=%h csx=0",
                 i, wr_q[i].dc, wr_q[i].data, wr_q[i].csx_fall, i != 0, words[i]); end
    end
    n_cmp++; if (csx !== 1'b1) begin n_err++; $display("FAIL burst_csx_close: got %b required 1", csx); end
  endtask

  task automatic test_random();
    logic [15:0] exp_data[$];
    logic        exp_dc[$];
    logic [15:0] d; logic dc, last, c, open;
    int g, acc, prev_acc, want;
    wr_q.delete();
    open = 1'b0; prev_acc = 0;
    for (int i = 0; i < 24; i++) begin
      d = 16'($urandom); dc = 1'($urandom_range(0, 1));
      last = (i == 23) ? 1'b1 : ($urandom_range(0, 3) == 0);
      g = (i == 0) ? 0 : int'($urandom_range(0, 8));
      repeat (g) @(negedge clk);
      send_word(dc, d, last, acc, c);
      if (i > 0) begin
        want = (g + 1 > 6) ? g + 1 : 6;
        n_cmp++; if (acc - prev_acc !== want) begin n_err++;
          $display("FAIL rand_gap[%0d]: got %0d required %0d", i, acc - prev_acc, want); end
      end
      n_cmp++; if (c !== !open) begin n_err++; $display("FAIL rand_csx_idle[%0d]: got %b required %b", i, c, !open); end
      open = !last;
      exp_data.push_back(d); exp_dc.push_back(dc);
      prev_acc = acc;
    end
    wait_idle();
    n_cmp++; if (wr_q.size() !== exp_data.size()) begin n_err++;
      $display("FAIL rand_count: got %0d required %0d", wr_q.size(), exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].data !== exp_data[i] || wr_q[i].dc !== exp_dc[i] || wr_q[i].low !== 2 ||
          wr_q[i].setup_ok !== 1'b1 || wr_q[i].csx_fall !== 1'b0) begin n_err++;
        $display("FAIL rand_word[%0d]: got dc=%b data=%h low=%0d ok=%b csx=%b required dc=%b data=%h low=2 ok=1 csx=0",
                 i, wr_q[i].dc, wr_q[i].data, wr_q[i].low, wr_q[i].setup_ok, wr_q[i].csx_fall, exp_dc[i], exp_data[i]); end
    end
    n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL bus_stable_wrx_low: got %0d changes required 0", unstable); end
  endtask

  task automatic test_sw_reset_mid();
    int a, budget, rel_k, done_k; logic c;
    wr_q.delete();
    send_word(1'b1, 16'h1234, 1'b1, a, c);
    @(negedge clk);
    n_cmp++; if (wrx !== 1'b0) begin n_err++; $display("FAIL swmid_in_wr_low: wrx=%b required 0", wrx); end
    sw_reset = 1'b1;
    @(negedge clk);
    sw_reset = 1'b0;
    budget = 20;
    while (lcd_reset_n !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
    n_cmp++; if (cyc - rise_cyc !== 2) begin n_err++;
      $display("FAIL swmid_hold_len: got %0d required 2", cyc - rise_cyc); end
    n_cmp++; if ({init_done, csx, busy} !== 3'b011) begin n_err++;
      $display("FAIL swmid_restart: got %b required 011", {init_done, csx, busy}); end
    n_cmp++; if (wr_q.size() !== 1) begin n_err++; $display("FAIL swmid_count: got %0d required 1", wr_q.size()); end
    if (wr_q.size() == 1) begin
      n_cmp++; if (wr_q[0].data !== 16'h1234 || wr_q[0].low !== 2) begin n_err++;
        $display("FAIL swmid_word: got data=%h low=%0d required data=1234 low=2", wr_q[0].data, wr_q[0].low); end
    end
    run_init_seq(rel_k, done_k);
    n_cmp++; if (rel_k !== 4 || done_k !== 10) begin n_err++;
      $display("FAIL swmid_reinit: got rel=%0d done=%0d required rel=4 done=10", rel_k, done_k); end
  endtask

  task automatic test_sw_reset_idle();
    int rel_k, done_k;
    wr_q.delete();
    in_valid = 1'b1; in_dc = 1'b0; in_data = 16'hABCD; in_last = 1'b1; sw_reset = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL swidle_ready: got %b required 0", in_ready); end
    @(negedge clk);
    sw_reset = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({lcd_reset_n, init_done, busy, csx} !== 4'b0011) begin n_err++;
      $display("FAIL swidle_restart: got %b required 0011", {lcd_reset_n, init_done, busy, csx}); end
    run_init_seq(rel_k, done_k);
    n_cmp++; if (rel_k !== 4 || done_k !== 10) begin n_err++;
      $display("FAIL swidle_reinit: got rel=%0d done=%0d required rel=4 done=10", rel_k, done_k); end
    n_cmp++; if (wr_q.size() !== 0) begin n_err++; $display("FAIL swidle_no_write: got %0d pulses required 0", wr_q.size()); end
  endtask

  task automatic test_async_abort();
    int a, rel_k, done_k; logic c;
    send_word(1'b1, 16'hBEEF, 1'b0, a, c);
    @(negedge clk);
    n_cmp++; if (wrx !== 1'b0) begin n_err++; $display("FAIL abort_in_wr_low: wrx=%b required 0", wrx); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({wrx, csx, rdx, lcd_reset_n, busy, in_ready} !== 6'b111010) begin n_err++;
      $display("FAIL abort_ctrl: got %b required 111010", {wrx, csx, rdx, lcd_reset_n, busy, in_ready}); end
    n_cmp++; if (data_out !== 16'h0) begin n_err++; $display("FAIL abort_data: got %h required 0000", data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    run_init_seq(rel_k, done_k);
    n_cmp++; if (rel_k !== 4 || done_k !== 10) begin n_err++;
      $display("FAIL abort_reinit: got rel=%0d done=%0d required rel=4 done=10", rel_k, done_k); end
    wr_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; sw_reset = 1'b0; in_valid = 1'b0; in_dc = 1'b0; in_last = 1'b0; in_data = 16'h0;
    test_reset();
    test_single();
    test_burst();
    test_random();
    test_sw_reset_mid();
    test_sw_reset_idle();
    test_async_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
